// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract, LSB first, sharing one full-adder cell.
// Result, cout and ovf are returned over a start/done handshake.
module adder_exercise (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf
);
   localparam int CW = $clog2(WIDTH) + 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] a_sr, b_sr;
   logic carry, sum_fa, cout_fa, last;

   adder_exercise u_fa (.a(a_sr[0]), .b(b_sr[0]), .cin(carry), .sum(sum_fa), .cout(cout_fa));

   assign last = cnt == CW'(WIDTH - 1);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;

   always_comb
      state_nx = (state == IDLE && start) ? RUN  :
                 (state == RUN && last)   ? DONE :
                 (state == DONE)          ? IDLE : state;

   always_comb begin
      busy = state == RUN;
      done = state == DONE;
   end

   // Subtract is A + ~B + 1, so the inversion and forced carry happen at capture.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         result <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
      end else if (state == IDLE && start) begin
         a_sr  <= op_a;
         b_sr  <= sub ? ~op_b : op_b;
         carry <= sub | cin;
         cnt   <= '0;
      end else if (state == RUN) begin
         result <= {sum_fa, result[WIDTH-1:1]};
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         carry  <= cout_fa;
         cnt    <= cnt + CW'(1);
         if (last) begin
            cout <= cout_fa;
            ovf  <= carry ^ cout_fa;
         end
      end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and randomized operations against an arithmetic model.
module tb_serial_add_ctrl;
   localparam int WIDTH = 8;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sub = 1'b0, cin = 1'b0;
   logic [WIDTH-1:0] op_a = '0, op_b = '0, result;
   logic busy, done, cout, ovf;
   int checks = 0, failures = 0;

   serial_add_ctrl #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .op_a(op_a), .op_b(op_b),
      .cin(cin), .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic s, input logic c, input bit glitch);
      logic [WIDTH-1:0] bb, er;
      logic [WIDTH:0] full;
      int c0, sm, n;
      logic ec, eo;
      bb = s ? ~b : b;
      c0 = s ? 1 : int'(c);
      full = {1'b0, a} + {1'b0, bb} + (WIDTH+1)'(c0);
      er = full[WIDTH-1:0];
      ec = full[WIDTH];
      sm = int'($signed(a)) + int'($signed(bb)) + c0;
      eo = (sm > 127) || (sm < -128);
      @(posedge clk); #1;
      start = 1'b1; op_a = a; op_b = b; sub = s; cin = c;
      @(posedge clk); #1;
      check("busy_at_T", busy, 1);
      start = 1'b0; op_a = WIDTH'($urandom); op_b = WIDTH'($urandom);
      sub = 1'($urandom); cin = 1'($urandom);
      n = 0;
      for (int k = 1; k <= WIDTH + 4; k++) begin
         @(posedge clk); #1;
         if (done) begin n = k; break; end
         check("busy_run", busy, 1);
         start = glitch && k == 3;
      end
      check("latency", n, WIDTH);
      check("busy_done", busy, 0);
      check("result", result, er);
      check("cout", cout, ec);
      check("ovf", ovf, eo);
      start = glitch;
      @(posedge clk); #1;
      check("done_width", done, 0);
      check("busy_idle", busy, 0);
      check("result_hold", result, er);
      start = 1'b0;
   endtask

   initial begin
      int seen;
      #12;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      check("rst_cout", cout, 0);
      check("rst_ovf", ovf, 0);
      rst_n = 1'b1;
      run_op(8'h0F, 8'h01, 0, 0, 0);
      run_op(8'hFF, 8'h01, 0, 0, 0);
      run_op(8'hFE, 8'h01, 0, 1, 0);
      run_op(8'h05, 8'h07, 1, 1, 0);
      run_op(8'h80, 8'h01, 1, 0, 0);
      run_op(8'h7F, 8'h01, 0, 0, 0);
      run_op(8'h11, 8'h22, 0, 0, 1);
      // Mid-operation reset discards the partial result and suppresses done.
      @(posedge clk); #1;
      start = 1'b1; op_a = 8'hAA; op_b = 8'h55; sub = 1'b0; cin = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_result", result, 0);
      check("arst_cout", cout, 0);
      check("arst_ovf", ovf, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         seen += int'(done) + int'(busy);
      end
      check("no_done_after_rst", seen, 0);
      run_op(8'h01, 8'h01, 0, 0, 0);
      for (int i = 0; i < 40; i++)
         run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 3) == 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
